// File: rtl/stream_byte_fifo.sv
// ---------------------------------------------------------------------------
// stream_byte_fifo
//   First-word-fall-through FIFO for a valid/ready byte stream. It absorbs
//   bursts while the downstream sink holds off ready. It also reports fill
//   level, the high-watermark and a sticky overflow flag.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   in_valid    upstream presents in_data
//   in_ready    FIFO can accept a word (level != DEPTH)
//   in_data     write data
//   out_valid   head word present (level != 0)
//   out_ready   downstream accepts the head word
//   out_data    head word (combinational read at rd_ptr)
//   level       current occupancy, 0..DEPTH
//   peak_level  highest occupancy since reset
//   overflow    sticky: in_valid seen while in_ready was low
// ---------------------------------------------------------------------------
module stream_byte_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   level,
   output logic [ADDR_WIDTH:0]   peak_level,
   output logic                  overflow
);

   // Natural pointer wrap only works for power-of-two depths.
   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("stream_byte_fifo: DEPTH must be a power of 2 and >= 2");
      end
      if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_addr_width
         $error("stream_byte_fifo: ADDR_WIDTH is derived from DEPTH and must not be overridden");
      end
   endgenerate

   localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   LEVEL_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_reg;
   logic [ADDR_WIDTH-1:0] rd_ptr_reg;
   logic [ADDR_WIDTH:0]   level_reg;
   logic [ADDR_WIDTH:0]   level_next;
   logic [ADDR_WIDTH:0]   peak_reg;
   logic [ADDR_WIDTH:0]   peak_next;
   logic                  overflow_reg;
   logic                  push;
   logic                  pop;

   // Full and empty come from level alone. The pointers carry no wrap bit.
   // in_ready is blocked on full even when a pop happens in the same cycle.
   // This keeps in_ready independent of out_ready and of in_valid.
   assign in_ready  = (level_reg != FULL_LEVEL);
   assign out_valid = (level_reg != '0);
   assign out_data  = mem[rd_ptr_reg];
   assign level      = level_reg;
   assign peak_level = peak_reg;
   assign overflow   = overflow_reg;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + LEVEL_ONE;
         2'b01:   level_next = level_reg - LEVEL_ONE;
         default: level_next = level_reg;
      endcase
   end

   // The watermark tracks the level that becomes visible after this edge.
   always_comb begin
      peak_next = peak_reg;
      if (level_next > peak_reg) begin
         peak_next = level_next;
      end
   end

   // Storage is not reset. Stale contents are hidden by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         peak_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         level_reg <= level_next;
         peak_reg  <= peak_next;
         if (in_valid && !in_ready) begin
            overflow_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stream_byte_fifo.sv
module tb_stream_byte_fifo;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] level;
   logic [3:0] peak_level;
   logic       overflow;

   int total;
   int bad;

   stream_byte_fifo #(
      .DATA_WIDTH(8),
      .DEPTH(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .level(level),
      .peak_level(peak_level),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle 1 ns past it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;

      // Reset, then idle for 5 cycles.
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("idle_in_ready",  32'(in_ready),   32'd1);
      chk("idle_out_valid", 32'(out_valid),  32'd0);
      chk("idle_level",     32'(level),      32'd0);
      chk("idle_peak",      32'(peak_level), 32'd0);
      chk("idle_overflow",  32'(overflow),   32'd0);

      // A single push falls through after one edge.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      step();
      in_valid = 1'b0;
      chk("single_out_valid", 32'(out_valid), 32'd1);
      chk("single_out_data",  32'(out_data),  32'hA5);
      chk("single_level",     32'(level),     32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("single_pop_level", 32'(level),     32'd0);
      chk("single_pop_valid", 32'(out_valid), 32'd0);

      // Fill to 8 entries, then offer one more word that must be dropped.
      for (int i = 1; i <= 8; i++) begin
         chk("fill_in_ready", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_data  = 8'(i);
         step();
      end
      chk("fill_level",    32'(level),      32'd8);
      chk("fill_in_ready", 32'(in_ready),   32'd0);
      chk("fill_peak",     32'(peak_level), 32'd8);
      chk("fill_no_ovf",   32'(overflow),   32'd0);
      in_data = 8'h09;
      step();
      in_valid = 1'b0;
      chk("ovf_set",   32'(overflow), 32'd1);
      chk("ovf_level", 32'(level),    32'd8);

      // Drain: 0x01..0x08 in order, and 0x09 never shows up.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_data",  32'(out_data),  32'(i));
         step();
      end
      out_ready = 1'b0;
      chk("drain_empty_valid", 32'(out_valid), 32'd0);
      chk("drain_empty_level", 32'(level),     32'd0);
      chk("ovf_sticky",        32'(overflow),  32'd1);
      chk("peak_held",         32'(peak_level), 32'd8);

      // Full with pop: only the pop happens. The push is taken next cycle.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h10 + i);
         step();
      end
      chk("fp_level_full", 32'(level), 32'd8);
      in_data   = 8'h18;
      out_ready = 1'b1;
      chk("fp_in_ready_low", 32'(in_ready), 32'd0);
      step();
      chk("fp_level_7",   32'(level),    32'd7);
      chk("fp_in_ready",  32'(in_ready), 32'd1);
      chk("fp_head",      32'(out_data), 32'h11);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk("fp_level_refill", 32'(level), 32'd8);
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("fp_drain_data", 32'(out_data), 32'(8'h10 + i));
         step();
      end
      out_ready = 1'b0;
      chk("fp_drain_level", 32'(level), 32'd0);

      // Asynchronous reset so the watermark and overflow start clean.
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      chk("rst_peak",     32'(peak_level), 32'd0);
      chk("rst_overflow", 32'(overflow),   32'd0);

      // Continuous stream for 20 cycles. The pointers wrap more than twice.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         in_data = 8'(c);
         step();
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_data",  32'(out_data),  32'(c));
         chk("stream_level", 32'(level),     32'd1);
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      chk("stream_end_level", 32'(level),      32'd0);
      chk("stream_peak",      32'(peak_level), 32'd1);
      chk("stream_no_ovf",    32'(overflow),   32'd0);

      // Reset mid-operation, applied between edges with 5 words buffered.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h50 + i);
         step();
      end
      in_valid = 1'b0;
      chk("mid_level_5", 32'(level), 32'd5);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_valid",    32'(out_valid), 32'd0);
      chk("mid_rst_level",    32'(level),     32'd0);
      chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
      #1 reset = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h3C;
      step();
      in_valid = 1'b0;
      chk("post_rst_valid", 32'(out_valid),  32'd1);
      chk("post_rst_data",  32'(out_data),   32'h3C);
      chk("post_rst_level", 32'(level),      32'd1);
      chk("post_rst_peak",  32'(peak_level), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
